// File: rtl/cliff_walk_step_multi.sv
// CliffWalking step engine for N_ENV environments, 2-stage pipeline.
// Define CW_TRUNC_EN to add per-env step counters and truncation.
module cliff_walk_step_multi #(
    parameter  int ROWS      = 4,
    parameter  int COLS      = 12,
    parameter  int N_ENV     = 32,
    parameter  int RWD_W     = 8,
    parameter  int MAX_STEPS = 100,
    localparam int STA_W     = $clog2(ROWS * COLS),
    localparam int ENV_W     = (N_ENV > 1) ? $clog2(N_ENV) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ena,
    input  logic             i_valid,
    input  logic             i_init,
    input  logic [ENV_W-1:0] i_env_id,
    input  logic [1:0]       i_act,
    output logic             o_valid,
    output logic [ENV_W-1:0] o_env_id,
    output logic [STA_W-1:0] o_sta,
    output logic [RWD_W-1:0] o_rwd,
    output logic             o_done,
    output logic             o_trunc
);

    localparam int START = (ROWS - 1) * COLS;
    localparam int GOAL  = ROWS * COLS - 1;

    localparam logic [STA_W-1:0] START_S = STA_W'(START);
    localparam logic [STA_W-1:0] GOAL_S  = STA_W'(GOAL);
    localparam logic [RWD_W-1:0] R_STEP  = RWD_W'(-1);
    localparam logic [RWD_W-1:0] R_CLIFF = RWD_W'(-100);
    localparam logic [ENV_W:0]   ENV_LIM = (ENV_W + 1)'(N_ENV);

    if (MAX_STEPS < 1) begin : g_bad_max_steps
        $error("MAX_STEPS must be at least 1");
    end

    // Per-environment position storage
    logic [STA_W-1:0] pos_q [N_ENV];

    // Stage A registers
    logic             a_vld_q;
    logic             a_init_q;
    logic [ENV_W-1:0] a_env_q;
    logic [1:0]       a_act_q;
    logic [STA_W-1:0] a_pos_q;

    logic             acc;
    logic             wb_en;
    logic             fwd;
    logic [STA_W-1:0] fetch_pos;

    logic [STA_W-1:0] step_sta;
    logic [STA_W-1:0] nxt_sta;
    logic [RWD_W-1:0] nxt_rwd;
    logic             nxt_done;
    logic             nxt_trunc;
    logic             restart;
    logic [STA_W-1:0] wb_pos;

    int row;
    int col;
    int nrow;
    int ncol;
    logic cliff;

    assign acc   = i_ena & i_valid & ({1'b0, i_env_id} < ENV_LIM);
    assign wb_en = i_ena & a_vld_q;

    // Back-to-back requests to one env see the value being written back
    assign fwd       = wb_en & (a_env_q == i_env_id);
    assign fetch_pos = fwd ? wb_pos : pos_q[i_env_id];

    always_comb begin
        row   = int'(a_pos_q) / COLS;
        col   = int'(a_pos_q) % COLS;
        nrow  = row;
        ncol  = col;
        unique case (a_act_q)
            2'd0:    if (row > 0)        nrow = row - 1;
            2'd1:    if (col < COLS - 1) ncol = col + 1;
            2'd2:    if (row < ROWS - 1) nrow = row + 1;
            default: if (col > 0)        ncol = col - 1;
        endcase
        cliff    = (nrow == ROWS - 1) && (ncol >= 1) && (ncol <= COLS - 2);
        step_sta = STA_W'(nrow * COLS + ncol);

        nxt_sta  = step_sta;
        nxt_rwd  = R_STEP;
        nxt_done = 1'b0;
        if (a_init_q) begin
            nxt_sta = START_S;
            nxt_rwd = '0;
        end else if (cliff) begin
            nxt_sta = START_S;
            nxt_rwd = R_CLIFF;
        end else if (step_sta == GOAL_S) begin
            nxt_done = 1'b1;
        end
    end

`ifdef CW_TRUNC_EN
    localparam int CNT_W = $clog2(MAX_STEPS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_STEPS);

    logic [CNT_W-1:0] cnt_q [N_ENV];
    logic [CNT_W-1:0] a_cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] wb_cnt;
    logic [CNT_W-1:0] fetch_cnt;

    assign cnt_inc   = a_cnt_q + CNT_W'(1);
    assign nxt_trunc = ~a_init_q & ~nxt_done & (cnt_inc == CNT_MAX);
    assign wb_cnt    = (a_init_q | restart) ? '0 : cnt_inc;
    assign fetch_cnt = fwd ? wb_cnt : cnt_q[i_env_id];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int e = 0; e < N_ENV; e++) begin
                cnt_q[e] <= '0;
            end
            a_cnt_q <= '0;
        end else if (i_ena) begin
            if (a_vld_q) begin
                cnt_q[a_env_q] <= wb_cnt;
            end
            if (acc) begin
                a_cnt_q <= fetch_cnt;
            end
        end
    end
`else
    assign nxt_trunc = 1'b0;
`endif

    // Terminal steps restart the env; the result still reports the terminal state
    assign restart = nxt_done | nxt_trunc;
    assign wb_pos  = restart ? START_S : nxt_sta;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int e = 0; e < N_ENV; e++) begin
                pos_q[e] <= START_S;
            end
        end else if (wb_en) begin
            pos_q[a_env_q] <= wb_pos;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_vld_q  <= 1'b0;
            a_init_q <= 1'b0;
            a_env_q  <= '0;
            a_act_q  <= '0;
            a_pos_q  <= START_S;
        end else if (i_ena) begin
            a_vld_q <= acc;
            if (acc) begin
                a_init_q <= i_init;
                a_env_q  <= i_env_id;
                a_act_q  <= i_act;
                a_pos_q  <= fetch_pos;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid  <= 1'b0;
            o_env_id <= '0;
            o_sta    <= '0;
            o_rwd    <= '0;
            o_done   <= 1'b0;
            o_trunc  <= 1'b0;
        end else if (i_ena) begin
            o_valid <= a_vld_q;
            if (a_vld_q) begin
                o_env_id <= a_env_q;
                o_sta    <= nxt_sta;
                o_rwd    <= nxt_rwd;
                o_done   <= nxt_done;
                o_trunc  <= nxt_trunc;
            end
        end
    end

endmodule

// File: tb/tb_cliff_walk_step_multi.sv
// Directed vector bench for cliff_walk_step_multi.
// Expected results are hand-computed grid positions and rewards.
module tb_cliff_walk_step_multi;

    localparam int NE = 20;
`ifdef CW_TRUNC_EN
    localparam int MS = 4;
`else
    localparam int MS = 100;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic       vld = 1'b0;
    logic       init = 1'b0;
    logic [4:0] env = '0;
    logic [1:0] act = '0;

    logic       ov;
    logic [4:0] oenv;
    logic [5:0] osta;
    logic [7:0] orwd;
    logic       odone;
    logic       otrunc;

    always #5 clk = ~clk;

    cliff_walk_step_multi #(
        .N_ENV    (NE),
        .MAX_STEPS(MS)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_ena   (ena),
        .i_valid (vld),
        .i_init  (init),
        .i_env_id(env),
        .i_act   (act),
        .o_valid (ov),
        .o_env_id(oenv),
        .o_sta   (osta),
        .o_rwd   (orwd),
        .o_done  (odone),
        .o_trunc (otrunc)
    );

    typedef struct {
        logic       ena;
        logic       vld;
        logic       init;
        logic [4:0] env;
        logic [1:0] act;
        logic [5:0] sta;
        logic [7:0] rwd;
        logic       done;
        logic       trunc;
    } vec_t;

    vec_t tbl[$];
    vec_t cur;
    vec_t ea;
    vec_t eo;
    logic ea_v = 1'b0;
    logic eo_v = 1'b0;

    int total = 0;
    int bad = 0;

    task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, a, e, $time);
        end
    endtask

    function automatic vec_t mk(bit e, bit v, bit in, int id, int a,
                                int s, int r, bit d, bit t);
        vec_t x;
        x.ena   = e;
        x.vld   = v;
        x.init  = in;
        x.env   = 5'(id);
        x.act   = 2'(a);
        x.sta   = 6'(s);
        x.rwd   = 8'(r);
        x.done  = d;
        x.trunc = t;
        return x;
    endfunction

    function automatic vec_t st(int id, int a, int s, int r, bit d);
        return mk(1, 1, 0, id, a, s, r, d, 0);
    endfunction

    function automatic vec_t idle();
        return mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic drive(vec_t x);
        @(posedge clk);
        #1;
        cur  = x;
        ena  = x.ena;
        vld  = x.vld;
        init = x.init;
        env  = x.env;
        act  = x.act;
    endtask

    // Expected-pipeline model: eo is what the outputs show now
    always @(negedge clk) begin
        if (rst) begin
            ea_v = 1'b0;
            eo_v = 1'b0;
            chk("rst_valid", 32'(ov), 0);
        end else begin
            chk("valid", 32'(ov), 32'(eo_v));
            if (eo_v) begin
                chk("env_id", 32'(oenv), 32'(eo.env));
                chk("sta", 32'(osta), 32'(eo.sta));
                chk("rwd", 32'(orwd), 32'(eo.rwd));
                chk("done", 32'(odone), 32'(eo.done));
                chk("trunc", 32'(otrunc), 32'(eo.trunc));
            end
            if (cur.ena) begin
                eo_v = ea_v;
                if (ea_v) eo = ea;
                ea_v = cur.vld && (int'(cur.env) < NE);
                if (ea_v) ea = cur;
            end
        end
    end

    initial begin
        cur = idle();
        cur.ena = 1'b0;

        tbl.push_back(st(0, 1, 36, -100, 0));
        tbl.push_back(idle());
        tbl.push_back(mk(1, 1, 1, 3, 0, 36, 0, 0, 0));
        tbl.push_back(st(3, 0, 24, -1, 0));
        tbl.push_back(st(3, 3, 24, -1, 0));
        tbl.push_back(st(5, 0, 24, -1, 0));
        tbl.push_back(st(5, 1, 25, -1, 0));
        tbl.push_back(st(5, 1, 26, -1, 0));
        tbl.push_back(st(20, 0, 0, 0, 0));
        tbl.push_back(st(25, 0, 0, 0, 0));
        tbl.push_back(st(19, 0, 24, -1, 0));
        tbl.push_back(mk(1, 1, 1, 19, 0, 36, 0, 0, 0));
        tbl.push_back(st(19, 0, 24, -1, 0));
        tbl.push_back(idle());
        tbl.push_back(st(1, 0, 24, -1, 0));
        tbl.push_back(st(2, 0, 24, -1, 0));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 1, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(st(1, 1, 25, -1, 0));
        tbl.push_back(st(2, 2, 36, -1, 0));
        tbl.push_back(st(1, 2, 36, -100, 0));
`ifndef CW_TRUNC_EN
        tbl.push_back(st(4, 2, 36, -1, 0));
        tbl.push_back(st(4, 0, 24, -1, 0));
        tbl.push_back(st(4, 0, 12, -1, 0));
        tbl.push_back(st(4, 0, 0, -1, 0));
        tbl.push_back(st(4, 0, 0, -1, 0));
        tbl.push_back(st(4, 3, 0, -1, 0));
        tbl.push_back(st(4, 1, 1, -1, 0));
        tbl.push_back(st(7, 0, 24, -1, 0));
        for (int k = 1; k <= 11; k++) tbl.push_back(st(7, 1, 24 + k, -1, 0));
        tbl.push_back(st(7, 2, 47, -1, 1));
        tbl.push_back(st(7, 0, 24, -1, 0));
        tbl.push_back(st(6, 0, 24, -1, 0));
        for (int k = 1; k <= 11; k++) tbl.push_back(st(6, 1, 24 + k, -1, 0));
        tbl.push_back(st(6, 1, 35, -1, 0));
`endif
        for (int k = 0; k < 3; k++) tbl.push_back(idle());

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_o_valid", 32'(ov), 0);
        chk("rst_o_env", 32'(oenv), 0);
        chk("rst_o_sta", 32'(osta), 0);
        chk("rst_o_rwd", 32'(orwd), 0);
        chk("rst_o_done", 32'(odone), 0);
        chk("rst_o_trunc", 32'(otrunc), 0);
        rst = 1'b0;

        foreach (tbl[i]) drive(tbl[i]);

        // Reset with requests in flight
        drive(st(1, 0, 24, -1, 0));
        drive(st(2, 0, 24, -1, 0));
        @(posedge clk);
        #1;
        cur = idle();
        vld = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(ov), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(st(5, 0, 24, -1, 0));
        drive(st(3, 0, 24, -1, 0));
        drive(st(7, 0, 24, -1, 0));
        drive(st(1, 1, 36, -100, 0));
        drive(st(0, 3, 36, -1, 0));
        repeat (3) drive(idle());

`ifdef CW_TRUNC_EN
        drive(st(9, 0, 24, -1, 0));
        drive(st(9, 2, 36, -1, 0));
        drive(st(9, 0, 24, -1, 0));
        drive(mk(1, 1, 0, 9, 2, 36, -1, 0, 1));
        drive(st(9, 0, 24, -1, 0));
        repeat (3) drive(idle());
`endif

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
